pre_add_stage: RTL and testbench

PRE_ADD_STAGE -- requirements
Module: pre_add_stage

---
 rtl/pre_add_stage_pkg.sv | 22 ++
 rtl/pre_add_stage_reg_mux.sv | 29 ++
 rtl/pre_add_stage.sv | 51 +++++
 tb/tb_pre_add_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pre_add_stage_pkg.sv
// Shared types and constants for the B-path pre-adder stage.
package pre_add_stage_pkg;

  localparam int DATA_W = 18;

  // Positions of the relevant bits within a full DSP opmode word.
  localparam int OPMODE_PRE_BIT = 4;
  localparam int OPMODE_SUB_BIT = 6;

  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic sub;      // opmode[6]: 1 = D-B, 0 = D+B
    logic use_pre;  // opmode[4]: 1 = forward pre-adder, 0 = forward B
  } opmode_t;

  // Unsigned modulo-2^DATA_W add/subtract; carry and borrow are dropped.
  function automatic data_t pre_add(input data_t a, input data_t b, input logic sub);
    return sub ? data_t'(a - b) : data_t'(a + b);
  endfunction

endpackage

// File: rtl/pre_add_stage_reg_mux.sv
// Optional pipeline register: sync reset, clock enable, and a static bypass select.
module reg_mux #(
  parameter int W   = 18,
  parameter bit REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] q;

  // NOTE: non-blocking assignment so every stage samples its neighbours'
  // pre-edge values; reset is tested first so it overrides the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (ce) begin
      q <= din;
    end
  end

  // The select is a constant, so the unused register is trimmed in bypass mode
  // and rst never reaches the bypassed path.
  assign dout = REG ? q : din;

endmodule

// File: rtl/pre_add_stage.sv
// DSP B-path front end: optional D/B/opmode registers, pre-adder, B1 output register.
module pre_add_stage
  import pre_add_stage_pkg::*;
#(
  parameter int DREG      = 1,
  parameter int B0REG     = 1,
  parameter int OPMODEREG = 1,
  parameter int B1REG     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ced,
  input  logic              ceb,
  input  logic              ceopmode,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] b,
  input  logic              opmode6,
  input  logic              opmode4,
  output logic [DATA_W-1:0] pre_out,
  output logic [DATA_W-1:0] b1_out
);

  data_t   d_s;
  data_t   b0_s;
  data_t   sel;
  opmode_t op_in;
  opmode_t op_s;

  assign op_in = '{sub: opmode6, use_pre: opmode4};

  reg_mux #(.W(DATA_W), .REG(DREG != 0)) u_dreg (
    .clk(clk), .rst(rst), .ce(ced), .din(d), .dout(d_s)
  );

  reg_mux #(.W(DATA_W), .REG(B0REG != 0)) u_b0reg (
    .clk(clk), .rst(rst), .ce(ceb), .din(b), .dout(b0_s)
  );

  // Both opcode bits share one register so they stay aligned with each other.
  reg_mux #(.W($bits(opmode_t)), .REG(OPMODEREG != 0)) u_opreg (
    .clk(clk), .rst(rst), .ce(ceopmode), .din(op_in), .dout(op_s)
  );

  assign pre_out = pre_add(d_s, b0_s, op_s.sub);
  assign sel     = op_s.use_pre ? pre_out : b0_s;

  reg_mux #(.W(DATA_W), .REG(B1REG != 0)) u_b1reg (
    .clk(clk), .rst(rst), .ce(ceb), .din(sel), .dout(b1_out)
  );

endmodule

// File: tb/tb_pre_add_stage.sv
// Directed bench for pre_add_stage: default pipeline via a scoreboard, plus a fully bypassed instance.
module tb_pre_add_stage;
  import pre_add_stage_pkg::*;

  logic  clk = 1'b0;
  logic  rst, ced, ceb, ceopmode, opmode6, opmode4;
  data_t d, b;
  data_t pre_out, b1_out, c_pre, c_b1;

  always #5 clk = ~clk;

  pre_add_stage u_dut (
    .clk(clk), .rst(rst), .ced(ced), .ceb(ceb), .ceopmode(ceopmode),
    .d(d), .b(b), .opmode6(opmode6), .opmode4(opmode4),
    .pre_out(pre_out), .b1_out(b1_out)
  );

  pre_add_stage #(.DREG(0), .B0REG(0), .OPMODEREG(0), .B1REG(0)) u_comb (
    .clk(clk), .rst(rst), .ced(ced), .ceb(ceb), .ceopmode(ceopmode),
    .d(d), .b(b), .opmode6(opmode6), .opmode4(opmode4),
    .pre_out(c_pre), .b1_out(c_b1)
  );

  typedef struct {
    int    due;
    data_t val;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;

  // Reference behaviour written directly from the stage's functional definition.
  function automatic data_t model(input data_t dv, input data_t bv, input logic o6, input logic o4);
    logic [DATA_W:0] full;
    full = o6 ? ({1'b0, dv} - {1'b0, bv}) : ({1'b0, dv} + {1'b0, bv});
    return o4 ? full[DATA_W-1:0] : bv;
  endfunction

  task automatic check(input string tag, input data_t obs, input data_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare every scoreboard entry due on this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
      e = exp_q.pop_front();
      check(e.tag, b1_out, e.val);
    end
  endtask

  // Drive one operand set; with default parameters it reaches b1_out two edges later.
  task automatic send(input string tag, input data_t dv, input data_t bv, input logic o6, input logic o4);
    exp_t e;
    d = dv; b = bv; opmode6 = o6; opmode4 = o4;
    e.due = cycle + 2;
    e.val = model(dv, bv, o6, o4);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; ced = 1'b1; ceb = 1'b1; ceopmode = 1'b1;
    d = '0; b = '0; opmode6 = 1'b0; opmode4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_b1", b1_out, '0);
    check("reset_pre", pre_out, '0);

    // Opmode register holds its reset value: add, B forward.
    ceopmode = 1'b0;
    d = 18'd5; b = 18'd3; opmode6 = 1'b1; opmode4 = 1'b1;
    tick();
    check("reset_op_add", pre_out, 18'd8);
    tick();
    check("reset_op_bfwd", b1_out, 18'd3);
    ceopmode = 1'b1;

    // Basic add: pre_out after one edge, b1_out after two.
    send("add_5_3", 18'd5, 18'd3, 1'b0, 1'b1);
    tick();
    check("add_pre_1edge", pre_out, 18'd8);
    tick();

    // Back-to-back stream through the pipeline.
    send("sub_wrap", 18'd3, 18'd5, 1'b1, 1'b1);
    tick();
    send("add_wrap", 18'h3FFFF, 18'd1, 1'b0, 1'b1);
    tick();
    send("bfwd_op6_0", 18'h15555, 18'h2AAAA, 1'b0, 1'b0);
    tick();
    send("bfwd_op6_1", 18'h15555, 18'h2AAAA, 1'b1, 1'b0);
    tick();
    send("sub_misc", 18'h01234, 18'h00FFF, 1'b1, 1'b1);
    tick();
    send("add_max", 18'h20000, 18'h20000, 1'b0, 1'b1);
    tick();
    tick();
    tick();

    // ceb=0 freezes B0 and B1 even with the other enables high.
    send("ceb_load", 18'd0, 18'd7, 1'b0, 1'b0);
    tick();
    tick();
    ceb = 1'b0;
    b = 18'd9;
    tick();
    check("ceb_hold_1", b1_out, 18'd7);
    tick();
    check("ceb_hold_2", b1_out, 18'd7);
    ceb = 1'b1;
    tick();
    check("ceb_resume_1", b1_out, 18'd7);
    tick();
    check("ceb_resume_2", b1_out, 18'd9);

    // Reset with data in flight discards it.
    send("flushed", 18'd100, 18'd1, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("rst_flush_b1", b1_out, '0);
    check("rst_flush_pre", pre_out, '0);
    rst = 1'b0;
    send("post_rst", 18'd20, 18'd22, 1'b0, 1'b1);
    tick();
    check("post_rst_early", b1_out, '0);
    tick();

    // Fully bypassed instance is combinational and ignores rst.
    d = 18'd10; b = 18'd4; opmode6 = 1'b1; opmode4 = 1'b1;
    #1;
    check("comb_sub", c_b1, 18'd6);
    check("comb_pre", c_pre, 18'd6);
    opmode4 = 1'b0;
    #1;
    check("comb_bfwd", c_b1, 18'd4);
    opmode6 = 1'b0; opmode4 = 1'b1;
    #1;
    check("comb_add", c_b1, 18'd14);
    rst = 1'b1;
    tick();
    check("comb_rst_ignored", c_b1, 18'd14);
    rst = 1'b0;

    check("scoreboard_drained", data_t'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
